// File: rtl/ddr3_cmd_decoder.sv
// ddr3_cmd_decoder: DDR3 command-bus receiver with init tracking, mode registers, bank state and protocol/timing checks
// Ports:
//   clk_i, rst_ni                       clock and asynchronous active-low reset
//   rst_neg_i, cke_i                    DRAM reset (active-low) and clock enable from the controller
//   cs_i, ras_i, cas_i, we_i            active-low command strobes
//   ba_i, a_i, odt_i                    bank, address, on-die termination
//   cmd_valid_o/cmd_code_o              registered decode (pulse on non-NOP)
//   cmd_bank_o/cmd_addr_o/odt_q_o       registered ba/a/odt
//   init_done_o, bank_open_o, mr0..3_o  init status, per-bank open flags, mode registers {ba,a}
//   err_valid_o/err_code_o/err_count_o  violation pulse, code and saturating count
module ddr3_cmd_decoder #(
  parameter int T_RCD = 5,
  parameter int T_RP  = 5,
  parameter int T_MRD = 4,
  parameter int CNT_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rst_neg_i,
  input  logic        cke_i,
  input  logic        cs_i,
  input  logic        ras_i,
  input  logic        cas_i,
  input  logic        we_i,
  input  logic [2:0]  ba_i,
  input  logic [15:0] a_i,
  input  logic        odt_i,
  output logic        cmd_valid_o,
  output logic [2:0]  cmd_code_o,
  output logic [2:0]  cmd_bank_o,
  output logic [15:0] cmd_addr_o,
  output logic        odt_q_o,
  output logic        init_done_o,
  output logic [7:0]  bank_open_o,
  output logic [18:0] mr0_o,
  output logic [18:0] mr1_o,
  output logic [18:0] mr2_o,
  output logic [18:0] mr3_o,
  output logic        err_valid_o,
  output logic [2:0]  err_code_o,
  output logic [7:0]  err_count_o
);
  typedef enum logic [2:0] {RESET_WAIT, CKE_WAIT, MRS_SEQ, ZQ_WAIT, READY} state_e;
  localparam logic [2:0] C_NOP = 3'd0, C_MRS = 3'd1, C_REF = 3'd2, C_PRE = 3'd3;
  localparam logic [2:0] C_ACT = 3'd4, C_WR = 3'd5, C_RD = 3'd6, C_ZQ = 3'd7;
  localparam logic [2:0] E_NONE = 3'd0, E_NRDY = 3'd1, E_ORD = 3'd2, E_OPEN = 3'd3;
  localparam logic [2:0] E_CLOSED = 3'd4, E_RCD = 3'd5, E_RP = 3'd6, E_MRD = 3'd7;
  localparam logic [CNT_W-1:0] RCD = CNT_W'(T_RCD), RP = CNT_W'(T_RP), MRD = CNT_W'(T_MRD);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_e state_q, state_d;
  logic [1:0] seq_q, seq_d;
  logic [7:0] open_q, open_d;
  logic [3:0][18:0] mr_q, mr_d;
  logic [7:0][CNT_W-1:0] act_cnt_q, act_cnt_d, pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] mrd_cnt_q, mrd_cnt_d;
  logic [2:0] code, err, exp_ba, cmd_code_q, cmd_bank_q, err_code_q;
  logic [15:0] cmd_addr_q;
  logic [7:0] err_count_q;
  logic tmrd, cmd_valid_q, odt_q, err_valid_q;

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] c);
    return &c ? c : c + ONE;
  endfunction

  // {ras,cas,we} = 111 is NOP and the remaining patterns map to codes in ascending order
  assign code = (cs_i || !cke_i) ? C_NOP : {ras_i, cas_i, we_i} + 3'd1;
  assign exp_ba = seq_q == 2'd0 ? 3'd2 : seq_q == 2'd1 ? 3'd3 : seq_q == 2'd2 ? 3'd1 : 3'd0;
  // elapsed counters read k at the edge k cycles after their event
  assign tmrd = code != C_NOP && mrd_cnt_q < MRD;

  always_comb begin
    state_d = state_q;
    seq_d = seq_q;
    open_d = open_q;
    mr_d = mr_q;
    mrd_cnt_d = inc(mrd_cnt_q);
    for (int i = 0; i < 8; i++) begin
      act_cnt_d[i] = inc(act_cnt_q[i]);
      pre_cnt_d[i] = inc(pre_cnt_q[i]);
    end
    err = E_NONE;
    if (!rst_neg_i) begin
      state_d = RESET_WAIT;
      seq_d = '0;
      open_d = '0;
      mr_d = '0;
    end else if (state_q != READY) begin
      if (state_q == RESET_WAIT) state_d = CKE_WAIT;
      if (state_q == CKE_WAIT && cke_i) state_d = MRS_SEQ;
      if (code == C_MRS && state_q == MRS_SEQ && ba_i == exp_ba) begin
        err = tmrd ? E_MRD : E_NONE;
        mr_d[ba_i[1:0]] = {ba_i, a_i};
        mrd_cnt_d = ONE;
        seq_d = seq_q + 2'd1;
        if (&seq_q) state_d = ZQ_WAIT;
      end else if (code == C_ZQ && state_q == ZQ_WAIT) begin
        err = tmrd ? E_MRD : E_NONE;
        state_d = READY;
      end else if (code == C_MRS) err = E_ORD;
      else if (code != C_NOP) err = E_NRDY;
    end else begin
      case (code)
        C_MRS: if (!ba_i[2]) begin
          err = |open_q ? E_OPEN : tmrd ? E_MRD : E_NONE;
          if (!(|open_q)) begin
            mr_d[ba_i[1:0]] = {ba_i, a_i};
            mrd_cnt_d = ONE;
          end
        end
        C_REF: err = |open_q ? E_OPEN : tmrd ? E_MRD : E_NONE;
        C_PRE: begin
          err = tmrd ? E_MRD : E_NONE;
          for (int i = 0; i < 8; i++)
            if (a_i[10] || ba_i == 3'(i)) begin
              open_d[i] = 1'b0;
              pre_cnt_d[i] = ONE;
            end
        end
        C_ACT: begin
          err = open_q[ba_i] ? E_OPEN : tmrd ? E_MRD : pre_cnt_q[ba_i] < RP ? E_RP : E_NONE;
          if (!open_q[ba_i]) begin
            open_d[ba_i] = 1'b1;
            act_cnt_d[ba_i] = ONE;
          end
        end
        C_WR, C_RD: err = !open_q[ba_i] ? E_CLOSED : tmrd ? E_MRD : act_cnt_q[ba_i] < RCD ? E_RCD : E_NONE;
        C_ZQ: err = tmrd ? E_MRD : E_NONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= RESET_WAIT;
      seq_q <= '0;
      open_q <= '0;
      mr_q <= '0;
      act_cnt_q <= '1;
      pre_cnt_q <= '1;
      mrd_cnt_q <= '1;
      cmd_valid_q <= 1'b0;
      cmd_code_q <= '0;
      cmd_bank_q <= '0;
      cmd_addr_q <= '0;
      odt_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      seq_q <= seq_d;
      open_q <= open_d;
      mr_q <= mr_d;
      act_cnt_q <= act_cnt_d;
      pre_cnt_q <= pre_cnt_d;
      mrd_cnt_q <= mrd_cnt_d;
      cmd_valid_q <= code != C_NOP;
      cmd_code_q <= code;
      cmd_bank_q <= ba_i;
      cmd_addr_q <= a_i;
      odt_q <= odt_i;
      err_valid_q <= err != E_NONE;
      err_code_q <= err;
      err_count_q <= (err != E_NONE && !(&err_count_q)) ? err_count_q + 8'd1 : err_count_q;
    end

  assign cmd_valid_o = cmd_valid_q;
  assign cmd_code_o = cmd_code_q;
  assign cmd_bank_o = cmd_bank_q;
  assign cmd_addr_o = cmd_addr_q;
  assign odt_q_o = odt_q;
  assign init_done_o = state_q == READY;
  assign bank_open_o = open_q;
  assign {mr3_o, mr2_o, mr1_o, mr0_o} = mr_q;
  assign err_valid_o = err_valid_q;
  assign err_code_o = err_code_q;
  assign err_count_o = err_count_q;
endmodule

// File: tb/tb_ddr3_cmd_decoder.sv
// tb_ddr3_cmd_decoder: directed and randomized check of ddr3_cmd_decoder against a timestamp-based reference model
module tb_ddr3_cmd_decoder;
  localparam int T_RCD = 5, T_RP = 5, T_MRD = 4;
  localparam int NOP = 0, MRS = 1, REF = 2, PRE = 3, ACT = 4, WR = 5, RD = 6, ZQ = 7;
  logic clk = 0, rst_n = 0, rst_neg = 0, cke = 0, cs = 1, ras = 1, cas = 1, we = 1, odt = 0;
  logic [2:0] ba = '0;
  logic [15:0] a = '0;
  logic cmd_valid, odt_q, init_done, err_valid;
  logic [2:0] cmd_code, cmd_bank, err_code;
  logic [15:0] cmd_addr;
  logic [7:0] bank_open, err_count;
  logic [18:0] mr0, mr1, mr2, mr3;

  always #5 clk = ~clk;

  ddr3_cmd_decoder #(.T_RCD(T_RCD), .T_RP(T_RP), .T_MRD(T_MRD), .CNT_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rst_neg_i(rst_neg), .cke_i(cke), .cs_i(cs), .ras_i(ras),
    .cas_i(cas), .we_i(we), .ba_i(ba), .a_i(a), .odt_i(odt), .cmd_valid_o(cmd_valid),
    .cmd_code_o(cmd_code), .cmd_bank_o(cmd_bank), .cmd_addr_o(cmd_addr), .odt_q_o(odt_q),
    .init_done_o(init_done), .bank_open_o(bank_open), .mr0_o(mr0), .mr1_o(mr1), .mr2_o(mr2),
    .mr3_o(mr3), .err_valid_o(err_valid), .err_code_o(err_code), .err_count_o(err_count)
  );

  int vectors = 0, miscompares = 0;
  logic [2:0] rcw [8] = '{3'b111, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
  int order [4] = '{2, 3, 1, 0};

  // reference model: init stage 0..7 (2..5 = waiting for the n-th MRS, 6 = ZQ, 7 = ready), event timestamps in cycles
  int stage, cyc = 0, t_mrs, m_cnt;
  int t_act [8], t_pre [8];
  logic [7:0] m_open;
  logic [18:0] m_mr [4];
  int m_code, m_err;
  logic [2:0] m_bank;
  logic [15:0] m_addr;
  logic m_odt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    stage = 0; m_open = '0; m_cnt = 0; m_code = 0; m_err = 0;
    m_bank = '0; m_addr = '0; m_odt = 1'b0; t_mrs = cyc - 100;
    for (int k = 0; k < 4; k++) m_mr[k] = '0;
    for (int k = 0; k < 8; k++) begin t_act[k] = cyc - 100; t_pre[k] = cyc - 100; end
  endtask

  task automatic model(input bit rn, input bit ck, input bit csn, input int c,
                       input logic [2:0] b, input logic [15:0] ad, input bit o);
    int e, nxt;
    bit ign, opn, cls, mrd, rcd, rp;
    cyc++;
    e = (csn || !ck) ? NOP : c;
    m_code = e; m_bank = b; m_addr = ad; m_odt = o; m_err = 0;
    mrd = e != NOP && cyc - t_mrs < T_MRD;
    if (!rn) begin
      stage = 0; m_open = '0;
      for (int k = 0; k < 4; k++) m_mr[k] = '0;
    end else if (stage < 7) begin
      nxt = stage;
      if (stage == 0) nxt = 1;
      else if (stage == 1 && ck) nxt = 2;
      if (e == MRS && stage >= 2 && stage <= 5 && int'(b) == order[stage-2]) begin
        m_err = mrd ? 7 : 0; m_mr[b[1:0]] = {b, ad}; t_mrs = cyc; nxt = stage + 1;
      end else if (e == ZQ && stage == 6) begin
        m_err = mrd ? 7 : 0; nxt = 7;
      end else if (e == MRS) m_err = 2;
      else if (e != NOP) m_err = 1;
      stage = nxt;
    end else begin
      ign = e == MRS && b[2];
      opn = (e == ACT && m_open[b]) || ((e == REF || (e == MRS && !ign)) && m_open != 0);
      cls = (e == RD || e == WR) && !m_open[b];
      mrd = mrd && !ign;
      rcd = (e == RD || e == WR) && cyc - t_act[b] < T_RCD;
      rp = e == ACT && cyc - t_pre[b] < T_RP;
      m_err = opn ? 3 : cls ? 4 : mrd ? 7 : rcd ? 5 : rp ? 6 : 0;
      if (!opn) begin
        if (e == MRS && !ign) begin m_mr[b[1:0]] = {b, ad}; t_mrs = cyc; end
        if (e == PRE)
          for (int k = 0; k < 8; k++)
            if (ad[10] || k == int'(b)) begin m_open[k] = 1'b0; t_pre[k] = cyc; end
        if (e == ACT) begin m_open[b] = 1'b1; t_act[b] = cyc; end
      end
    end
    if (m_err != 0 && m_cnt < 255) m_cnt++;
  endtask

  task automatic step(input bit rn, input bit ck, input bit csn, input int c,
                      input logic [2:0] b, input logic [15:0] ad);
    @(negedge clk);
    rst_neg = rn; cke = ck; cs = csn; ba = b; a = ad; odt = 1'($urandom);
    {ras, cas, we} = csn ? 3'($urandom) : rcw[c];
    model(rn, ck, csn, c, b, ad, odt);
    @(posedge clk);
    #1;
    check("cmd", {cmd_valid, cmd_code, cmd_bank, cmd_addr, odt_q}, {1'(m_code != 0), 3'(m_code), m_bank, m_addr, m_odt});
    check("err", {err_valid, err_code}, {1'(m_err != 0), 3'(m_err)});
    check("err_count", err_count, m_cnt);
    check("init_done", init_done, stage == 7);
    check("bank_open", bank_open, m_open);
    check("mr", {mr3, mr2, mr1, mr0}, {m_mr[3], m_mr[2], m_mr[1], m_mr[0]});
  endtask

  task automatic cmd(input int c, input logic [2:0] b, input logic [15:0] ad);
    step(1, 1, 0, c, b, ad);
  endtask

  task automatic nop(input int n);
    for (int k = 0; k < n; k++) cmd(NOP, 3'($urandom), 16'($urandom));
  endtask

  task automatic do_init();
    step(0, 0, 1, NOP, 0, 0);
    step(1, 0, 1, NOP, 0, 0);
    step(1, 1, 1, NOP, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cmd(MRS, 3'(order[k]), 16'h0A55);
      nop(3);
    end
    cmd(ZQ, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {cmd_valid, cmd_code, cmd_bank, cmd_addr, odt_q, err_valid, err_code, err_count, init_done, bank_open}, '0);
    check({tag, "_mr"}, {mr3, mr2, mr1, mr0}, '0);
  endtask

  initial begin
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1;
    do_init();
    check("init_done_after_zq", init_done, 1);
    check("init_mr0", mr0, 19'h00A55);
    check("init_errs", err_count, 0);
    cmd(ACT, 3, 16'h1234); nop(4); cmd(RD, 3, 0);
    check("rd_ok", {err_valid, bank_open}, {1'b0, 8'h08});
    cmd(PRE, 3, 0); nop(4); cmd(ACT, 3, 16'h1234); nop(2); cmd(RD, 3, 0);
    check("rd_trcd", {err_valid, err_code, bank_open}, {1'b1, 3'd5, 8'h08});
    cmd(ACT, 1, 0); cmd(ACT, 1, 0);
    check("act_open", err_code, 3);
    cmd(RD, 2, 0);
    check("rd_closed", {err_code, cmd_valid, cmd_code}, {3'd4, 1'b1, 3'd6});
    cmd(ACT, 0, 0); cmd(ACT, 5, 0); cmd(PRE, 0, 16'h0400);
    check("pre_all", bank_open, 0);
    nop(1); cmd(ACT, 5, 0);
    check("act_trp", err_code, 6);
    step(0, 1, 1, NOP, 0, 0);
    check("rst_neg", {init_done, bank_open, mr3, mr2, mr1, mr0}, '0);
    step(1, 0, 1, NOP, 0, 0);
    step(1, 1, 1, NOP, 0, 0);
    cmd(MRS, 1, 16'h0111);
    check("mrs_order1", err_code, 2);
    cmd(MRS, 3, 16'h0333);
    check("mrs_order3", {err_code, mr3}, {3'd2, 19'h0});
    cmd(WR, 0, 0);
    check("wr_not_ready", err_code, 1);
    for (int r = 0; r < 15; r++) begin
      do_init();
      for (int k = 0; k < 120; k++)
        step($urandom_range(199) != 0, $urandom_range(19) != 0, $urandom_range(9) == 0,
             $urandom_range(2) == 0 ? NOP : int'($urandom_range(7)),
             $urandom_range(4) == 0 ? 3'($urandom_range(7)) : 3'($urandom_range(1)),
             16'($urandom));
    end
    do_init();
    cmd(ACT, 2, 0);
    @(negedge clk);
    rst_neg = 1; cke = 1; cs = 0; {ras, cas, we} = rcw[ACT]; ba = 3'd4;
    #2 rst_n = 0;
    #1;
    check_all_zero("async_rst");
    cs = 1; rst_neg = 0;
    model_reset();
    @(negedge clk) rst_n = 1;
    step(1, 0, 1, NOP, 0, 0);
    cmd(RD, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
